mastermind_scoreboard: RTL and testbench

- Downstream of the guess-evaluation datapath: consumes one {red, white} feedback result per completed guess.
- Tracks guess count, detects win/loss, and drives the HEX feedback digits and game-status LEDs.
- Holds a per-game history of all results, readable by index for the display scroller.
- Gates upstream guess entry via accept_guess.

---
 rtl/mastermind_pkg.sv | 35 +++
 rtl/mastermind_scoreboard_if.sv | 23 ++
 rtl/mastermind_history_ram.sv | 47 ++++
 rtl/mastermind_scoreboard.sv | 138 +++++++++++++
 tb/tb_mastermind_scoreboard.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind scoreboard slice.
// Game states, result record and the well-formed-result check live here.
package mastermind_pkg;

   localparam int PEGS_DEF        = 4;
   localparam int MAX_GUESSES_DEF = 8;
   localparam int CNT_W_DEF       = 4;
   localparam int COLOR_W         = 3;
   localparam int DISP_W          = 4;

   localparam logic [DISP_W-1:0] WIN_DISP  = 4'h8;
   localparam logic [DISP_W-1:0] LOSE_DISP = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WIN  = 2'd2,
      LOSE = 2'd3
   } game_state_t;

   typedef struct packed {
      logic [COLOR_W-1:0] red;
      logic [COLOR_W-1:0] white;
   } result_t;

   // Sum is taken one bit wider than the colour fields so 7+7 cannot wrap.
   function automatic logic result_well_formed(input logic [COLOR_W-1:0] red,
                                               input logic [COLOR_W-1:0] white,
                                               input int                 pegs);
      logic [COLOR_W:0] sum;
      sum = {1'b0, red} + {1'b0, white};
      return (red <= COLOR_W'(pegs)) && (sum <= (COLOR_W+1)'(pegs));
   endfunction

endpackage

// File: rtl/mastermind_scoreboard_if.sv
// Result handshake between the guess-evaluation datapath (master)
// and the scoreboard (slave).
interface mastermind_scoreboard_if;
   import mastermind_pkg::*;

   logic               new_game;
   logic               result_valid;
   logic [COLOR_W-1:0] red_in;
   logic [COLOR_W-1:0] white_in;
   logic               accept_guess;
   logic               protocol_err;

   modport master (
      output new_game, result_valid, red_in, white_in,
      input  accept_guess, protocol_err
   );

   modport slave (
      input  new_game, result_valid, red_in, white_in,
      output accept_guess, protocol_err
   );

endinterface

// File: rtl/mastermind_history_ram.sv
// Per-game result history: synchronous write, registered read.
// A same-cycle read of the slot being written returns the old contents.
module mastermind_history_ram
   import mastermind_pkg::*;
#(
   parameter int DEPTH  = MAX_GUESSES_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  result_t           wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output result_t           rd_data
);

   result_t mem_q [DEPTH];
   result_t rd_data_q;
   result_t rd_data_d;

   always_comb begin
      rd_data_d = '0;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // Storage carries no reset so it can map onto RAM; validity is tracked by the caller.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mastermind_scoreboard.sv
// Mastermind scoreboard: counts guesses, decides win/loss, drives HEX/LED status
// and keeps a readable history. Define MASTERMIND_BEST_SCORE_EN to track best score.
module mastermind_scoreboard
   import mastermind_pkg::*;
#(
   parameter int PEGS        = PEGS_DEF,
   parameter int MAX_GUESSES = MAX_GUESSES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   mastermind_scoreboard_if.slave  res,
   output logic [1:0]              game_state,
   output logic [CNT_W-1:0]        guess_count,
   output logic [DISP_W-1:0]       disp_red,
   output logic [DISP_W-1:0]       disp_white,
   input  logic [CNT_W-1:0]        hist_rd_idx,
   output logic [COLOR_W-1:0]      hist_rd_red,
   output logic [COLOR_W-1:0]      hist_rd_white,
   output logic [CNT_W-1:0]        best_score
);

   localparam int ADDR_W = $clog2(MAX_GUESSES);

   game_state_t       state_q, state_d;
   logic [CNT_W-1:0]  guess_count_q, guess_count_d;
   logic [DISP_W-1:0] disp_red_q, disp_red_d;
   logic [DISP_W-1:0] disp_white_q, disp_white_d;
   logic              protocol_err_q, protocol_err_d;

   logic              hist_wr_en;
   result_t           hist_wr_data;
   logic              hist_rd_en;
   result_t           hist_rd_data;

   // new_game overrides everything; results only count while playing.
   always_comb begin
      state_d        = state_q;
      guess_count_d  = guess_count_q;
      disp_red_d     = disp_red_q;
      disp_white_d   = disp_white_q;
      protocol_err_d = 1'b0;
      hist_wr_en     = 1'b0;
      hist_wr_data   = '{red: res.red_in, white: res.white_in};

      if (res.new_game) begin
         state_d       = PLAY;
         guess_count_d = '0;
         disp_red_d    = '0;
         disp_white_d  = '0;
      end else if (state_q == PLAY && res.result_valid) begin
         if (result_well_formed(res.red_in, res.white_in, PEGS)) begin
            hist_wr_en    = 1'b1;
            guess_count_d = guess_count_q + CNT_W'(1);
            disp_red_d    = {1'b0, res.red_in};
            disp_white_d  = {1'b0, res.white_in};
            if (res.red_in == COLOR_W'(PEGS)) begin
               state_d      = WIN;
               disp_red_d   = WIN_DISP;
               disp_white_d = WIN_DISP;
            end else if (guess_count_d == CNT_W'(MAX_GUESSES)) begin
               state_d      = LOSE;
               disp_red_d   = LOSE_DISP;
               disp_white_d = LOSE_DISP;
            end
         end else begin
            protocol_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= IDLE;
         guess_count_q  <= '0;
         disp_red_q     <= '0;
         disp_white_q   <= '0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         guess_count_q  <= guess_count_d;
         disp_red_q     <= disp_red_d;
         disp_white_q   <= disp_white_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   // Slots at or beyond the current count belong to no guess of this game.
   assign hist_rd_en = (hist_rd_idx < guess_count_q);

   mastermind_history_ram #(
      .DEPTH  (MAX_GUESSES),
      .ADDR_W (ADDR_W)
   ) u_history (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (hist_wr_en),
      .wr_addr (guess_count_q[ADDR_W-1:0]),
      .wr_data (hist_wr_data),
      .rd_en   (hist_rd_en),
      .rd_addr (hist_rd_idx[ADDR_W-1:0]),
      .rd_data (hist_rd_data)
   );

`ifdef MASTERMIND_BEST_SCORE_EN
   logic [CNT_W-1:0] best_score_q, best_score_d;

   always_comb begin
      best_score_d = best_score_q;
      if (state_q == PLAY && state_d == WIN &&
          (best_score_q == '0 || guess_count_d < best_score_q)) begin
         best_score_d = guess_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         best_score_q <= '0;
      end else begin
         best_score_q <= best_score_d;
      end
   end

   assign best_score = best_score_q;
`else
   assign best_score = '0;
`endif

   assign res.accept_guess = (state_q == PLAY);
   assign res.protocol_err = protocol_err_q;
   assign game_state       = state_q;
   assign guess_count      = guess_count_q;
   assign disp_red         = disp_red_q;
   assign disp_white       = disp_white_q;
   assign hist_rd_red      = hist_rd_data.red;
   assign hist_rd_white    = hist_rd_data.white;

endmodule

// File: tb/tb_mastermind_scoreboard.sv
// Directed scoreboard bench for mastermind_scoreboard; expected results are
// queued as stimulus is driven and popped one cycle later when sampled.
module tb_mastermind_scoreboard;
   import mastermind_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] hist_rd_idx = 4'd0;
   logic [1:0] game_state;
   logic [3:0] guess_count;
   logic [3:0] disp_red;
   logic [3:0] disp_white;
   logic [2:0] hist_rd_red;
   logic [2:0] hist_rd_white;
   logic [3:0] best_score;

   int total = 0;
   int bad = 0;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic [3:0] cnt;
      logic [3:0] dr;
      logic [3:0] dw;
      logic [3:0] best;
      logic       err;
      logic       acc;
   } exp_t;

   exp_t       expq[$];
   logic [5:0] histq[$];

   int         m_state;
   int         m_count;
   int         m_dr;
   int         m_dw;
   int         m_best;
   logic       m_err;
   logic [5:0] m_hist [16];

   mastermind_scoreboard_if res_if ();

   mastermind_scoreboard dut (
      .clk           (clk),
      .resetn        (resetn),
      .res           (res_if.slave),
      .game_state    (game_state),
      .guess_count   (guess_count),
      .disp_red      (disp_red),
      .disp_white    (disp_white),
      .hist_rd_idx   (hist_rd_idx),
      .hist_rd_red   (hist_rd_red),
      .hist_rd_white (hist_rd_white),
      .best_score    (best_score)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pushExpected(input string tag);
      exp_t e;
      e.tag  = tag;
      e.st   = 2'(m_state);
      e.cnt  = 4'(m_count);
      e.dr   = 4'(m_dr);
      e.dw   = 4'(m_dw);
      e.best = 4'(m_best);
      e.err  = m_err;
      e.acc  = (m_state == 1);
      expq.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expq.size() == 0) begin
         total++;
         bad++;
         $error("[TB] FAIL scoreboard_empty: observed=0 expected=1");
         return;
      end
      e = expq.pop_front();
      chk({e.tag, ".state"},  8'(game_state),            8'(e.st));
      chk({e.tag, ".count"},  8'(guess_count),           8'(e.cnt));
      chk({e.tag, ".dred"},   8'(disp_red),              8'(e.dr));
      chk({e.tag, ".dwhite"}, 8'(disp_white),            8'(e.dw));
      chk({e.tag, ".perr"},   8'(res_if.protocol_err),   8'(e.err));
      chk({e.tag, ".accept"}, 8'(res_if.accept_guess),   8'(e.acc));
      chk({e.tag, ".best"},   8'(best_score),            8'(e.best));
   endtask

   // Reference behaviour of one clock edge with resetn high.
   task automatic modelStep(input logic ng, input logic rv, input int r, input int w);
      m_err = 1'b0;
      if (ng) begin
         m_state = 1;
         m_count = 0;
         m_dr    = 0;
         m_dw    = 0;
      end else if (m_state == 1 && rv) begin
         if (r <= 4 && r + w <= 4) begin
            m_hist[m_count] = {3'(r), 3'(w)};
            m_count++;
            if (r == 4) begin
               m_state = 2;
               m_dr    = 8;
               m_dw    = 8;
`ifdef MASTERMIND_BEST_SCORE_EN
               if (m_best == 0 || m_count < m_best) m_best = m_count;
`endif
            end else if (m_count == 8) begin
               m_state = 3;
               m_dr    = 15;
               m_dw    = 15;
            end else begin
               m_dr = r;
               m_dw = w;
            end
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic applyStimulus(input string tag, input logic ng, input logic rv,
                                input int r, input int w);
      @(negedge clk);
      res_if.new_game     = ng;
      res_if.result_valid = rv;
      res_if.red_in       = 3'(r);
      res_if.white_in     = 3'(w);
      modelStep(ng, rv, r, w);
      pushExpected(tag);
      @(posedge clk);
      #1;
      res_if.new_game     = 1'b0;
      res_if.result_valid = 1'b0;
      checkOutput();
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      resetn              = 1'b0;
      res_if.new_game     = 1'b0;
      res_if.result_valid = 1'b0;
      m_state = 0;
      m_count = 0;
      m_dr    = 0;
      m_dw    = 0;
      m_err   = 1'b0;
      m_best  = 0;
      pushExpected(tag);
      @(posedge clk);
      #1;
      checkOutput();
      chk({tag, ".hred"},   8'(hist_rd_red),   8'd0);
      chk({tag, ".hwhite"}, 8'(hist_rd_white), 8'd0);
      resetn = 1'b1;
   endtask

   task automatic readHist(input string tag, input int idx);
      logic [5:0] e;
      @(negedge clk);
      hist_rd_idx = 4'(idx);
      histq.push_back((idx < m_count) ? m_hist[idx] : 6'd0);
      @(posedge clk);
      #1;
      e = histq.pop_front();
      chk({tag, ".hred"},   8'(hist_rd_red),   8'(e[5:3]));
      chk({tag, ".hwhite"}, 8'(hist_rd_white), 8'(e[2:0]));
   endtask

   // Read the slot being written in the same cycle: the old (empty) value must come back.
   task automatic collideStep(input string tag, input int r, input int w);
      logic [5:0] e;
      @(negedge clk);
      hist_rd_idx = 4'(m_count);
      histq.push_back(6'd0);
      applyStimulus(tag, 1'b0, 1'b1, r, w);
      e = histq.pop_front();
      chk({tag, ".hred"},   8'(hist_rd_red),   8'(e[5:3]));
      chk({tag, ".hwhite"}, 8'(hist_rd_white), 8'(e[2:0]));
   endtask

   task automatic playGame(input string tag, input int n);
      applyStimulus({tag, ".ng"}, 1'b1, 1'b0, 0, 0);
      for (int i = 0; i < n - 1; i++) applyStimulus({tag, ".miss"}, 1'b0, 1'b1, 1, 2);
      applyStimulus({tag, ".win"}, 1'b0, 1'b1, 4, 0);
   endtask

   initial begin
      res_if.new_game     = 1'b0;
      res_if.result_valid = 1'b0;
      res_if.red_in       = 3'd0;
      res_if.white_in     = 3'd0;
      for (int i = 0; i < 16; i++) m_hist[i] = 6'd0;

      doReset("reset");
      applyStimulus("idle_rv", 1'b0, 1'b1, 1, 1);

      applyStimulus("g1.ng", 1'b1, 1'b0, 0, 0);
      collideStep("g1.r0", 1, 2);
      readHist("g1.h0_after", 0);
      applyStimulus("g1.r1", 1'b0, 1'b1, 0, 3);
      applyStimulus("g1.r2", 1'b0, 1'b1, 4, 0);
      for (int i = 0; i < 4; i++) readHist("g1.hist", i);
      applyStimulus("g1.win_rv", 1'b0, 1'b1, 2, 2);

      applyStimulus("g2.ng", 1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus("g2.r", 1'b0, 1'b1, 2, 1);
      applyStimulus("g2.lose_rv", 1'b0, 1'b1, 4, 0);
      readHist("g2.h7", 7);
      readHist("g2.h8", 8);

      applyStimulus("g3.ng", 1'b1, 1'b0, 0, 0);
      applyStimulus("g3.edge04", 1'b0, 1'b1, 0, 4);
      applyStimulus("g3.bad32", 1'b0, 1'b1, 3, 2);
      applyStimulus("g3.after32", 1'b0, 1'b0, 0, 0);
      applyStimulus("g3.bad50", 1'b0, 1'b1, 5, 0);
      applyStimulus("g3.bad77", 1'b0, 1'b1, 7, 7);
      applyStimulus("g3.ng_rv", 1'b1, 1'b1, 4, 0);
      readHist("g3.h0", 0);

      for (int i = 0; i < 5; i++) applyStimulus("g4.r", 1'b0, 1'b1, 1, 1);
      doReset("midreset");
      applyStimulus("g4.idle_rv", 1'b0, 1'b1, 4, 0);
      readHist("g4.h0", 0);
      applyStimulus("g4.ng", 1'b1, 1'b0, 0, 0);

      playGame("best5", 5);
      playGame("best3", 3);
      playGame("best6", 6);
      applyStimulus("best.ng", 1'b1, 1'b0, 0, 0);

      if (expq.size() != 0 || histq.size() != 0) begin
         total++;
         bad++;
         $error("[TB] FAIL scoreboard_leftover: observed=%0d expected=0",
                expq.size() + histq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
